// File: rtl/nxu8_dbg_pkg.sv
// nxu8_dbg_pkg: shared state encoding and command byte layout for the debug command sequencer
package nxu8_dbg_pkg;
  typedef enum logic [2:0] {
    S_IDLE, S_DATA_H, S_DATA_L, S_ISSUE, S_WAIT, S_RESP_H, S_RESP_L, S_ACK
  } state_t;
  localparam int CMD_WR_BIT = 7;
  localparam int CMD_ADDR_MSB = 6;
  localparam logic [7:0] ACK_BYTE_DEF = 8'h06;
  function automatic logic rx_state(input state_t s);
    return s inside {S_IDLE, S_DATA_H, S_DATA_L};
  endfunction
endpackage

// File: rtl/nxu8_gap_timer.sv
// nxu8_gap_timer: inter-byte gap counter; expires after TIMEOUT_CYC idle cycles, 0 disables
module nxu8_gap_timer #(
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);
  localparam int W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [W-1:0] LAST = W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
  localparam bit ON = TIMEOUT_CYC > 0;
  logic [W-1:0] cnt_q, cnt_d;
  // a byte in the expiry cycle clears the counter and suppresses the expiry
  assign o_expire = ON && i_en && !i_clr && cnt_q == LAST;
  assign cnt_d = (!ON || i_clr || !i_en || o_expire) ? '0 : cnt_q + 1'b1;
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/nxu8_dbg_cmd.sv
// nxu8_dbg_cmd: parses host read/write command bytes, runs one SerDes transfer per command
// and returns read data or a write acknowledge on the host TX path.
module nxu8_dbg_cmd import nxu8_dbg_pkg::*; #(
  parameter logic [7:0] ACK_BYTE = ACK_BYTE_DEF,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_valid,
  output logic        o_rx_ready,
  output logic [7:0]  o_tx_data,
  output logic        o_tx_valid,
  input  logic        i_tx_ready,
  output logic        o_sd_start,
  output logic [6:0]  o_sd_addr,
  output logic [15:0] o_sd_data,
  output logic        o_sd_wr,
  input  logic [15:0] i_sd_data,
  input  logic        i_sd_busy,
  input  logic        i_sd_valid,
  output logic        o_timeout
);
  state_t state_q, state_d;
  logic rx_ready_q, wr_q, timeout_q;
  logic [6:0] addr_q;
  logic [15:0] data_q, resp_q;
  logic rx_fire, in_data, expire, sd_valid_unused;
  assign sd_valid_unused = i_sd_valid;
  assign rx_fire = i_rx_valid && rx_ready_q;
  assign in_data = state_q inside {S_DATA_H, S_DATA_L};
  nxu8_gap_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
    .i_clk(i_clk), .i_rst(i_rst), .i_clr(rx_fire), .i_en(in_data), .o_expire(expire)
  );
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   state_d = rx_fire ? (i_rx_data[CMD_WR_BIT] ? S_DATA_H : S_ISSUE) : S_IDLE;
      S_DATA_H: state_d = rx_fire ? S_DATA_L : expire ? S_IDLE : S_DATA_H;
      S_DATA_L: state_d = rx_fire ? S_ISSUE : expire ? S_IDLE : S_DATA_L;
      S_ISSUE:  state_d = i_sd_busy ? S_ISSUE : S_WAIT;
      S_WAIT:   state_d = i_sd_busy ? S_WAIT : wr_q ? S_ACK : S_RESP_H;
      S_RESP_H: state_d = i_tx_ready ? S_RESP_L : S_RESP_H;
      default:  state_d = i_tx_ready ? S_IDLE : state_q;
    endcase
  end
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      state_q <= S_IDLE;
      rx_ready_q <= 1'b0;
      wr_q <= 1'b0;
      timeout_q <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      resp_q <= '0;
    end else begin
      state_q <= state_d;
      rx_ready_q <= rx_state(state_d);
      timeout_q <= expire;
      if (rx_fire && state_q == S_IDLE) begin
        addr_q <= i_rx_data[CMD_ADDR_MSB:0];
        wr_q <= i_rx_data[CMD_WR_BIT];
      end
      if (rx_fire && state_q == S_DATA_H) data_q[15:8] <= i_rx_data;
      if (rx_fire && state_q == S_DATA_L) data_q[7:0] <= i_rx_data;
      // read data is taken when busy falls even if the SerDes never flagged it valid
      if (state_q == S_WAIT && !i_sd_busy && !wr_q) resp_q <= i_sd_data;
    end
  assign o_rx_ready = rx_ready_q;
  assign o_sd_start = state_q == S_ISSUE && !i_sd_busy;
  assign o_sd_addr = addr_q;
  assign o_sd_data = data_q;
  assign o_sd_wr = wr_q;
  assign o_timeout = timeout_q;
  assign o_tx_valid = state_q inside {S_RESP_H, S_RESP_L, S_ACK};
  assign o_tx_data = state_q == S_RESP_H ? resp_q[15:8] :
                     state_q == S_RESP_L ? resp_q[7:0] :
                     state_q == S_ACK ? ACK_BYTE : 8'h00;
endmodule
